// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gray_pkg
//  Brief    : State encoding and width default shared by the Gray arbiter.
//  Revision : 1.0
// ============================================================================
package gray_pkg;

    localparam int c_DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gray_core.sv
`default_nettype none
// ============================================================================
//  Module   : gray_core
//  Brief    : Binary counter with Gray-coded view and sticky wrap flag.
//  Revision : 1.0
// ============================================================================
module gray_core
    import gray_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] Gray,
    output logic             Overflow
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (En) begin
            r_cnt <= r_cnt + WIDTH'(1);
            // Wrapping from all-ones latches the flag until the next reset
            if (&r_cnt)
                r_ovf <= 1'b1;
        end
    end

    assign cnt      = r_cnt;
    assign Gray     = r_cnt ^ (r_cnt >> 1);
    assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/gray_arb.sv
`default_nettype none
// ============================================================================
//  Module   : gray_arb
//  Brief    : Round-robin arbiter granting two requesters a shared Gray counter
//             for a requested number of increments.
//  Revision : 1.0
// ============================================================================
module gray_arb
    import gray_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Steps0,
    input  logic [WIDTH-1:0] Steps1,
    output logic             Grant0,
    output logic             Grant1,
    output logic             Done0,
    output logic             Done1,
    output logic             Busy,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_last;
    logic             r_owner;
    logic             r_grant0;
    logic             r_grant1;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;

    logic             w_en;
    logic             w_pick1;
    logic [WIDTH-1:0] w_steps;
    logic [WIDTH-1:0] w_cnt;

    // Requester 1 wins when alone, or when both ask and 0 was served last
    assign w_pick1 = Req1 && (!Req0 || !r_last);
    assign w_steps = w_pick1 ? Steps1 : Steps0;
    assign w_en    = (r_state == RUN);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Req0 || Req1) begin
                        r_owner  <= w_pick1;
                        r_grant0 <= !w_pick1;
                        r_grant1 <= w_pick1;
                        r_busy   <= 1'b1;
                        r_rem    <= w_steps;
                        if (w_steps == '0) begin
                            r_state <= DONE;
                            r_done0 <= !w_pick1;
                            r_done1 <= w_pick1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= r_rem - WIDTH'(1);
                    if (r_rem == WIDTH'(1)) begin
                        r_state <= DONE;
                        r_done0 <= !r_owner;
                        r_done1 <= r_owner;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_last   <= r_owner;
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    gray_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (w_en),
        .cnt      (w_cnt),
        .Gray     (Output),
        .Overflow (Overflow)
    );

    assign Grant0 = r_grant0;
    assign Grant1 = r_grant1;
    assign Done0  = r_done0;
    assign Done1  = r_done1;
    assign Busy   = r_busy;

    a_gray_view: assert property (@(posedge Clk) disable iff (Reset)
        Output == (w_cnt ^ (w_cnt >> 1)));

endmodule
`default_nettype wire

// File: tb/tb_gray_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_arb
//  Brief    : Randomized scoreboard bench for gray_arb against a transaction model.
//  Revision : 1.0
// ============================================================================
module tb_gray_arb;

    localparam int W = 3;

    logic         Clk, Reset, Req0, Req1;
    logic [W-1:0] Steps0, Steps1, Output;
    logic         Grant0, Grant1, Done0, Done1, Busy, Overflow;

    typedef struct {
        int who;
        int cnt;
        int ovf;
        int steps;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_cnt, m_ovf, m_last;

    gray_arb #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req0     (Req0),
        .Req1     (Req1),
        .Steps0   (Steps0),
        .Steps1   (Steps1),
        .Grant0   (Grant0),
        .Grant1   (Grant1),
        .Done0    (Done0),
        .Done1    (Done1),
        .Busy     (Busy),
        .Output   (Output),
        .Overflow (Overflow)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever @(posedge Clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required earlier finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int c);
        return c ^ (c >> 1);
    endfunction

    // Transaction-level model: one completed operation adds steps to the count
    task automatic model_op(input int who, input int steps);
        exp_t e;
        int   sum;
        sum = m_cnt + steps;
        if (sum >= (1 << W)) m_ovf = 1;
        m_cnt   = sum % (1 << W);
        m_last  = who;
        e.who   = who;
        e.cnt   = m_cnt;
        e.ovf   = m_ovf;
        e.steps = steps;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_ovf  = 0;
        m_last = 1;
        sb.delete();
    endtask

    // Monitor: pops the scoreboard on every Done pulse
    initial begin
        exp_t e;
        int   g_cyc;
        bit   prev_g, prev_done;
        g_cyc = 0; prev_g = 0; prev_done = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_g = 0;
                prev_done = 0;
            end else begin
                chk("grant_overlap", int'(Grant0 & Grant1), 0);
                chk("busy_vs_grant", int'(Busy), int'(Grant0 | Grant1));
                if (prev_done) chk("idle_after_done", int'(Grant0 | Grant1), 0);
                if ((Grant0 | Grant1) && !prev_g) g_cyc = cyc;
                if (Done0 | Done1) begin
                    chk("done_overlap", int'(Done0 & Done1), 0);
                    chk("done_one_cycle", int'(prev_done), 0);
                    if (sb.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_who", int'(Done1), e.who);
                        chk("owner_grant", int'(e.who ? Grant1 : Grant0), 1);
                        chk("output_gray", int'(Output), gray(e.cnt));
                        chk("overflow", int'(Overflow), e.ovf);
                        chk("latency", cyc - g_cyc, e.steps);
                    end
                end
                prev_g    = Grant0 | Grant1;
                prev_done = Done0 | Done1;
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic do_round(input bit use0, input bit use1, input int s0, input int s1, input bit drop_mid);
        int first, need, got;
        first = (use0 && use1) ? ((m_last == 1) ? 0 : 1) : (use1 ? 1 : 0);
        need  = (use0 && use1) ? 2 : 1;
        model_op(first, first ? s1 : s0);
        if (need == 2) model_op(1 - first, first ? s0 : s1);
        @(negedge Clk);
        Req0 = use0; Req1 = use1; Steps0 = W'(s0); Steps1 = W'(s1);
        got = 0;
        for (int t = 0; t < 100 && got < need; t++) begin
            @(negedge Clk);
            if (Done0) begin Req0 = 1'b0; got++; end
            if (Done1) begin Req1 = 1'b0; got++; end
            // Steps is only sampled at grant, so scrambling it afterwards must be harmless
            if (Grant0 && !Done0) begin Steps0 = W'($urandom); if (drop_mid) Req0 = 1'b0; end
            if (Grant1 && !Done1) begin Steps1 = W'($urandom); if (drop_mid) Req1 = 1'b0; end
        end
        chk("round_complete", got, need);
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic both_cont(input int n);
        int got;
        for (int i = 0; i < n; i++) model_op((m_last == 1) ? 0 : 1, 1);
        @(negedge Clk);
        Req0 = 1'b1; Req1 = 1'b1; Steps0 = W'(1); Steps1 = W'(1);
        got = 0;
        for (int t = 0; t < 200 && got < n; t++) begin
            @(negedge Clk);
            if (Done0 | Done1) got++;
        end
        Req0 = 1'b0; Req1 = 1'b0;
        chk("cont_complete", got, n);
    endtask

    initial begin
        int seq[3];
        int ok;
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Steps0 = '0; Steps1 = '0;
        model_reset();
        #1;
        chk("rst_grant0", int'(Grant0), 0);
        chk("rst_grant1", int'(Grant1), 0);
        chk("rst_done", int'(Done0 | Done1), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_output", int'(Output), 0);
        chk("rst_overflow", int'(Overflow), 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Exact-cycle walk of a 3-step operation from reset
        seq = '{1, 3, 2};
        model_op(0, 3);
        Req0 = 1'b1; Steps0 = W'(3);
        @(posedge Clk); #1;
        chk("d_grant0", int'(Grant0), 1);
        chk("d_out0", int'(Output), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("d_out_step", int'(Output), seq[i]);
            chk("d_done_timing", int'(Done0), (i == 2) ? 1 : 0);
        end
        Req0 = 1'b0;
        chk("d_overflow", int'(Overflow), 0);
        @(posedge Clk); #1;
        chk("d_idle_grant", int'(Grant0), 0);
        chk("d_idle_done", int'(Done0), 0);

        // Wrap at the 8th increment
        do_reset();
        do_round(1, 0, 5, 0, 0);
        do_round(0, 1, 0, 4, 0);
        chk("wrap_output", int'(Output), 1);
        chk("wrap_overflow", int'(Overflow), 1);
        do_round(1, 0, 2, 0, 0);
        chk("wrap_sticky", int'(Overflow), 1);

        both_cont(4);
        do_round(1, 0, 0, 0, 0);
        do_round(0, 1, 0, 0, 0);
        do_round(1, 0, 6, 0, 1);
        do_round(1, 1, 3, 2, 1);

        // Asynchronous reset in the middle of a run
        @(negedge Clk);
        Req1 = 1'b1; Steps1 = W'(7);
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge Clk);
            if (Grant1) ok = 1;
        end
        chk("mid_grant_seen", ok, 1);
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("mid_grant", int'(Grant1), 0);
        chk("mid_busy", int'(Busy), 0);
        chk("mid_done", int'(Done1), 0);
        chk("mid_output", int'(Output), 0);
        chk("mid_overflow", int'(Overflow), 0);
        Req1 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        repeat (4) @(negedge Clk);
        do_round(0, 1, 0, 2, 0);

        for (int r = 0; r < 40; r++) begin
            bit u0, u1;
            u0 = 1'($urandom);
            u1 = 1'($urandom);
            if (!u0 && !u1) u0 = 1'b1;
            do_round(u0, u1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge Clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_arb.md
GRAY_ARB -- requirements
Module: gray_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning counter and Gray output width.
REQ-002 SHALL have port Clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Req0, input, 1, requester 0 asks for counter ownership; held high until Done0.
REQ-005 SHALL have port Req1, input, 1, requester 1 asks for counter ownership; held high until Done1.
REQ-006 SHALL have port Steps0, input, WIDTH, number of increments requester 0 wants; sampled only at grant.
REQ-007 SHALL have port Steps1, input, WIDTH, number of increments requester 1 wants; sampled only at grant.
REQ-008 SHALL have port Grant0/Grant1, output, 1 each, the owner of the counter, one-hot or zero.
REQ-009 SHALL have port Done0/Done1, output, 1 each, one-cycle completion pulse to the owner.
REQ-010 SHALL have port Busy, output, 1, high in RUN and DONE.
REQ-011 SHALL have port Output, output, WIDTH, Gray code of the internal binary count.
REQ-012 SHALL have port Overflow, output, 1, sticky flag for a counter wrap.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 In IDLE with no request, SHALL stay in IDLE; Grant, Done and Busy are low.
REQ-015 In IDLE with one request, SHALL grant that requester at the next edge and latch its Steps into a remaining register rem.
REQ-016 In IDLE with both requests, SHALL grant the requester not served last; after reset, requester 0 has priority.
REQ-017 Grant transition: if the latched Steps is nonzero, SHALL go IDLE->RUN; if zero, SHALL go IDLE->DONE with no increment.
REQ-018 In RUN, each edge SHALL increment binary count cnt by 1 (mod 2^WIDTH) and decrement rem.
REQ-019 SHALL go RUN->DONE on the edge where rem==1, so exactly Steps increments occur.
REQ-020 In DONE, SHALL assert the owner's Done for exactly one cycle, keep Grant high, then go to IDLE and record the owner as last served.
REQ-021 Latency: Req seen at edge k gives Grant after k, the last increment at edge k+N, Done in the cycle after k+N, and IDLE after k+N+1.
REQ-022 A Req still high in IDLE after Done SHALL count as a new request, subject to round-robin.
REQ-023 Deasserting Req during RUN/DONE SHALL NOT abort; the operation completes.
REQ-024 Output SHALL equal cnt ^ (cnt >> 1), combinational from cnt.
REQ-025 cnt SHALL persist across operations and is never cleared except by Reset.
REQ-026 An increment from all-ones to zero SHALL set Overflow at that edge; Overflow stays set until Reset.

Reset
REQ-027 While Reset is high, asynchronously: state=IDLE, cnt=0, rem=0, Overflow=0, last-served=1 (requester 0 favoured), all Grant/Done/Busy low, Output=0.
REQ-028 Reset mid-RUN SHALL abandon the operation with no Done pulse; the first edge after release evaluates IDLE.

Structure
REQ-029 Shared package gray_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant 3.
REQ-030 SHALL instantiate one sub-module gray_core (inputs Clk, Reset, En; outputs cnt, Gray, Overflow); the arbiter FSM drives En high only in RUN.

Verification
REQ-031 Reset, Req0=1 Steps0=3 -> Grant0 after edge 1, Output 001,011,010 after edges 2-4, Done0 in cycle 5, Overflow=0.
REQ-032 Req0 and Req1 both high continuously, Steps=1 each -> grants alternate 0,1,0,1; no Grant overlap.
REQ-033 Steps0=0 -> IDLE->DONE, Done0 one cycle after grant, cnt unchanged.
REQ-034 Two operations of Steps=5 then 4 from cnt=0 -> wrap at the 8th increment, Overflow=1 and stays 1, final Output=001 (cnt=1).
REQ-035 Reset asserted mid-RUN, between edges -> outputs 0 immediately, no Done pulse; a new Req1 afterwards is served normally.
REQ-036 Req0 dropped during RUN -> remaining increments still happen and Done0 pulses.
